// File: rtl/al_pkg.sv
// Shared PROM auto-load constants and FSM state type, used by the reader and
// by the auto-load sequencer so both agree on opcode, stop address and blank word.
package al_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        WRITE
    } al_state_t;

    localparam logic [7:0]  PROM_READ_OP  = 8'h03;
    localparam logic [5:0]  AL_MAX_ADDR   = 6'd33;
    localparam logic [15:0] AL_BLANK_WORD = 16'hFFFF;

endpackage

// File: rtl/al_spi_shifter.sv
// 32-bit SPI read frame shifter: opcode, address byte, then 16 data bits in,
// two clocks per bit (SCK low then high), MSB first.
module al_spi_shifter
    import al_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [5:0]  addr,
    input  logic        so,
    output logic        cs_b,
    output logic        sck,
    output logic        si,
    output logic        done,
    output logic [15:0] rx_word
);

    logic [31:0] frame;
    logic [30:0] tx_sr;
    logic [14:0] rx_sr;
    logic [4:0]  bit_idx;
    logic        active;

    assign frame = {PROM_READ_OP, 2'b00, addr, 16'h0000};

    // done marks the edge that ends the last SCK-high cycle, so the final SO
    // bit is folded into rx_word combinationally for capture on that edge.
    assign done    = active && sck && (bit_idx == 5'd31);
    assign rx_word = {rx_sr, so};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sr   <= '0;
            rx_sr   <= '0;
            bit_idx <= '0;
            active  <= 1'b0;
            cs_b    <= 1'b1;
            sck     <= 1'b0;
            si      <= 1'b0;
        end else if (abort) begin
            bit_idx <= '0;
            active  <= 1'b0;
            cs_b    <= 1'b1;
            sck     <= 1'b0;
            si      <= 1'b0;
        end else if (start) begin
            tx_sr   <= frame[30:0];
            si      <= frame[31];
            bit_idx <= '0;
            active  <= 1'b1;
            cs_b    <= 1'b0;
            sck     <= 1'b0;
        end else if (active) begin
            if (!sck) begin
                sck <= 1'b1;
            end else begin
                sck <= 1'b0;
                if (bit_idx >= 5'd16) begin
                    rx_sr <= {rx_sr[13:0], so};
                end
                if (bit_idx == 5'd31) begin
                    active <= 1'b0;
                    cs_b   <= 1'b1;
                    si     <= 1'b0;
                end else begin
                    si      <= tx_sr[30];
                    tx_sr   <= {tx_sr[29:0], 1'b0};
                    bit_idx <= bit_idx + 5'd1;
                end
            end
        end
    end

endmodule

// File: rtl/al_prom_reader.sv
// PROM auto-load reader: one 16-bit SPI read per accepted EXECUTE, with address
// counter and done/abort detection. Optional checksum via `define AL_CHKSUM_EN.
module al_prom_reader
    import al_pkg::*;
#(
    parameter logic [5:0]  MAX_ADDR   = AL_MAX_ADDR,
    parameter logic [15:0] BLANK_WORD = AL_BLANK_WORD
) (
    input  logic        CLK,
    input  logic        RST_B,
    input  logic        AL_ENA,
    input  logic        EXECUTE,
    input  logic        INC,
    input  logic        RST_ADDR,
    input  logic        CLR_AL_DONE,
    output logic [5:0]  ADDR,
    output logic        BUSY,
    output logic        AL_DONE,
    output logic        PROM_CS_B,
    output logic        PROM_SCK,
    output logic        PROM_SI,
    input  logic        PROM_SO,
    output logic [15:0] DATA,
    output logic [5:0]  DATA_ADDR,
`ifdef AL_CHKSUM_EN
    output logic        CHKSUM_ERR,
`endif
    output logic        DATA_WE
);

    al_state_t   state;
    logic        accept;
    logic        abort;
    logic        shift_done;
    logic        write_ok;
    logic        set_done;
    logic [15:0] rx_word;

    assign accept   = EXECUTE && AL_ENA && !BUSY;
    assign abort    = !AL_ENA && (state != IDLE);
    assign write_ok = (state == WRITE) && AL_ENA;
    assign set_done = write_ok &&
                      (((DATA_ADDR == 6'd0) && (DATA == BLANK_WORD)) ||
                       (DATA_ADDR == MAX_ADDR - 6'd1));

    // The shifter takes ADDR directly on the accept edge, since DATA_ADDR is
    // only being loaded on that same edge.
    al_spi_shifter u_shifter (
        .clk     (CLK),
        .rst_n   (RST_B),
        .start   (accept),
        .abort   (abort),
        .addr    (ADDR),
        .so      (PROM_SO),
        .cs_b    (PROM_CS_B),
        .sck     (PROM_SCK),
        .si      (PROM_SI),
        .done    (shift_done),
        .rx_word (rx_word)
    );

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            state     <= IDLE;
            BUSY      <= 1'b0;
            DATA      <= '0;
            DATA_ADDR <= '0;
            DATA_WE   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    DATA_WE <= 1'b0;
                    if (accept) begin
                        state     <= SHIFT;
                        BUSY      <= 1'b1;
                        DATA_ADDR <= ADDR;
                    end
                end
                SHIFT: begin
                    if (!AL_ENA) begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end else if (shift_done) begin
                        state   <= WRITE;
                        DATA    <= rx_word;
                        DATA_WE <= 1'b1;
                    end
                end
                WRITE: begin
                    state   <= IDLE;
                    BUSY    <= 1'b0;
                    DATA_WE <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    BUSY    <= 1'b0;
                    DATA_WE <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            ADDR <= '0;
        end else if (RST_ADDR) begin
            ADDR <= '0;
        end else if (INC) begin
            ADDR <= ADDR + 6'd1;
        end
    end

    // A completing read that sets the flag beats a simultaneous clear.
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            AL_DONE <= 1'b0;
        end else if (set_done) begin
            AL_DONE <= 1'b1;
        end else if (CLR_AL_DONE) begin
            AL_DONE <= 1'b0;
        end
    end

`ifdef AL_CHKSUM_EN
    logic [15:0] chk_sum;

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            chk_sum    <= '0;
            CHKSUM_ERR <= 1'b0;
        end else begin
            if (CLR_AL_DONE) begin
                chk_sum <= '0;
            end else if (write_ok && (DATA_ADDR < MAX_ADDR - 6'd1)) begin
                chk_sum <= chk_sum + DATA;
            end
            if (write_ok && (DATA_ADDR == MAX_ADDR - 6'd1)) begin
                CHKSUM_ERR <= (DATA != chk_sum);
            end else if (CLR_AL_DONE) begin
                CHKSUM_ERR <= 1'b0;
            end
        end
    end
`endif

endmodule
